// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM-side types plus the arbiter's grant kind and FSM state.
package cpu_types_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef logic [31:0] word_t;
    typedef enum logic {DATA, INSTR} arb_kind_t;
    typedef enum logic {IDLE, XFER} arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: rotate-priority find-first; returns the first set req bit at or after ptr.
module rr_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    always_comb begin
        valid = |req;
        idx = '0;
        // Walk offsets downward so the smallest offset from ptr is written last and wins.
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-CPU round-robin RAM arbiter with separate data/instruction pointers,
// grant locking, instruction starvation guard and RAM error hold.
module mem_arbiter_rr
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int MAX_DGRANTS = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);
    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int CW = $clog2(MAX_DGRANTS + 1);
    localparam logic [CW-1:0] DMAX = CW'(MAX_DGRANTS);

    arb_state_t state_q, state_d;
    arb_kind_t kind_q, kind_d;
    logic [IW-1:0] owner_q, owner_d, dptr_q, dptr_d, iptr_q, iptr_d, didx, iidx;
    logic [CW-1:0] dcount_q, dcount_d;
    logic [CPUS-1:0] dreq;
    logic dvalid, ivalid, any_i, forced, own_req, done;

    assign dreq = dREN | dWEN;
    assign any_i = |iREN;
    assign forced = (dcount_q == DMAX) && any_i;
    assign own_req = (kind_q == DATA) ? dreq[owner_q] : iREN[owner_q];
    assign done = (state_q == XFER) && own_req && (ramstate_t'(ramstate) == ACCESS);

    rr_pick #(.N(CPUS)) u_dpick (.req(dreq), .ptr(dptr_q), .valid(dvalid), .idx(didx));
    rr_pick #(.N(CPUS)) u_ipick (.req(iREN), .ptr(iptr_q), .valid(ivalid), .idx(iidx));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            kind_q <= DATA;
            owner_q <= '0;
            dptr_q <= '0;
            iptr_q <= '0;
            dcount_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q <= kind_d;
            owner_q <= owner_d;
            dptr_q <= dptr_d;
            iptr_q <= iptr_d;
            dcount_q <= dcount_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d = kind_q;
        owner_d = owner_q;
        dptr_d = dptr_q;
        iptr_d = iptr_q;
        if (state_q == IDLE) begin
            if (dvalid && !forced) begin
                state_d = XFER;
                kind_d = DATA;
                owner_d = didx;
            end else if (ivalid) begin
                state_d = XFER;
                kind_d = INSTR;
                owner_d = iidx;
            end
        end else if (!own_req || done) begin
            state_d = IDLE;
        end
        if (done && kind_q == DATA) dptr_d = IW'((int'(owner_q) + 1) % CPUS);
        if (done && kind_q == INSTR) iptr_d = IW'((int'(owner_q) + 1) % CPUS);
        dcount_d = !any_i ? '0 :
                   (done && kind_q == INSTR) ? '0 :
                   (done && dcount_q != DMAX) ? dcount_q + 1'b1 : dcount_q;
    end

    always_comb begin
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        ramREN = 1'b0;
        ramWEN = 1'b0;
        ramaddr = '0;
        ramstore = '0;
        if (state_q == XFER && kind_q == DATA) begin
            ramaddr = daddr[owner_q*ADDR_W +: ADDR_W];
            ramWEN = dWEN[owner_q];
            ramREN = !dWEN[owner_q];
            ramstore = dWEN[owner_q] ? dstore[owner_q*WORD_W +: WORD_W] : '0;
            dwait[owner_q] = !done;
            dload[owner_q*WORD_W +: WORD_W] = (done && !dWEN[owner_q]) ? ramload : '0;
        end else if (state_q == XFER) begin
            ramREN = 1'b1;
            ramaddr = iaddr[owner_q*ADDR_W +: ADDR_W];
            iwait[owner_q] = !done;
            iload[owner_q*WORD_W +: WORD_W] = done ? ramload : '0;
        end
    end
endmodule
